synth_phase_osc: RTL
====================

// Module: synth_phase_osc
// PURPOSE
//  - Per-voice phase-accumulator oscillator. Sits directly downstream of the synth update-clock divider.
//  - Advances a phase accumulator once per rising edge of the 1 MHz Syn_clk update clock.
//  - Emits one signed 16-bit sample per update: saw, square, triangle or noise. Samples feed the voice mixer / AC97 output path.
//  - Frequency words are loaded via a valid/ready handshake and applied only at phase wrap, so pitch changes are glitch-free.
// PARAMETERS
//  ACC_W      24        phase accumulator width; f_out = Freq_word * 1 MHz / 2^ACC_W
//  LFSR_SEED  16'hACE1  noise LFSR reset value; must be nonzero
// PORTS
//  Sys_clk     in   1      system clock, 100 MHz; only clock in the block
//  Syn_rst     in   1      synchronous, active-high reset
//  Syn_ce      in   1      active-high enable; low = hold all state
//  Syn_clk     in   1      update clock from the divider; rising edge = one update tick
//  Freq_word   in   ACC_W  phase increment
//  Freq_valid  in   1      Freq_word valid
//  Freq_ready  out  1      block can accept a Freq_word
//  Wave_sel    in   2      00 saw, 01 square, 10 triangle, 11 noise
//  Pulse_width in   16     square duty threshold (used only with SYNTH_OSC_PWM_EN)
//  Sample      out  16     signed two's-complement sample
//  Sample_val  out  1      one-Sys_clk pulse when Sample updates
//  Phase_wrap  out  1      one-Sys_clk pulse, coincident with Sample_val, when the accumulator carried out
// BEHAVIOUR
//  - Reset: phase=0, active_freq=0, pending empty, LFSR=LFSR_SEED, Sample=0, Sample_val=0, Phase_wrap=0, Freq_ready=1.
//  - Tick detection: syn_q <= Syn_clk each enabled cycle; tick = Syn_clk & ~syn_q. Exactly one tick per Syn_clk period.
//  - At tick edge k: phase <= phase + active_freq (mod 2^ACC_W); LFSR steps once.
//  - At edge k+1: Sample is registered from the new phase, and Sample_val=1. Latency is 1 Sys_clk after the tick.
//  - Phase_wrap=1 on the same cycle as Sample_val if the add at edge k carried out.
//  - Waveforms use p = phase[ACC_W-1 -: 16]:
//    - saw = p ^ 16'h8000
//    - square = (p < duty) ? 16'h7FFF : 16'h8000
//    - triangle: t = p[15] ? ~p[14:0] : p[14:0]; sample = {t,1'b0} ^ 16'h8000
//    - noise = LFSR state; Fibonacci, taps 16,14,13,11; shift left; feedback enters bit 0
//  - Wave_sel is sampled at Sample registration. A change takes effect on the next sample; phase is not disturbed.
//  - Handshake:
//    - Transfer occurs when Freq_valid & Freq_ready; the word goes to pending, and Freq_ready drops on the next cycle.
//    - Pending is copied to active_freq at a tick whose add carries out; the new increment is used from the following tick.
//    - If active_freq==0, pending is copied on the cycle after transfer (no wrap wait).
//    - Freq_ready returns to 1 on the cycle after the copy.
//    - If a transfer and a wrap tick occur in the same cycle, the word waits for the next wrap.
//  - Syn_ce=0: phase, LFSR, syn_q, pending and Sample are all held. Sample_val=0 and Phase_wrap=0. No transfer occurs (Freq_ready held low).
//  - Syn_rst wins over Syn_ce. Reset mid-operation discards pending and the in-flight sample.
// CONFIGURATION
//  - SYNTH_OSC_PWM_EN defined: duty = Pulse_width.
//  - SYNTH_OSC_PWM_EN undefined: duty = 16'h8000 (50 %); the Pulse_width port exists but is ignored.
// STRUCTURE
//  - synth_pkg: WAVE_SAW/SQR/TRI/NOI encodings, SAMPLE_W=16, S_MAX=16'h7FFF, S_MIN=16'h8000, LFSR tap constants.
//  - Sub-module synth_lfsr (16-bit, step enable, seed parameter).
//  - Accumulator, handshake and wave mux live in the top module.
// TESTING
//  1. Reset, load 24'h100000, saw:
//     - first Sample=16'h9000, then +16'h1000 per update
//     - Phase_wrap on the 16th Sample_val (Sample=16'h8000)
//  2. Same frequency, square, PWM off: samples 1-7 = 16'h7FFF, samples 8-15 = 16'h8000, sample 16 (p=0) = 16'h7FFF.
//  3. Triangle, 24'h100000:
//     - sample at p=16'h7000 is 16'h6000
//     - sample at p=16'h8000 is 16'h7FFE
//     - p=0 gives 16'h8000
//  4. Write 24'h200000 at tick 5:
//     - Freq_ready low; step stays 16'h1000 until the wrap at tick 16
//     - then step 16'h2000; Freq_ready high 1 cycle after the wrap
//  5. Syn_ce low for 300 Sys_clk: zero Sample_val; Sample and phase unchanged; resumes from the same phase.
//  6. Syn_rst mid-period with a word pending: next cycle Sample=0, Freq_ready=1, active_freq=0; noise output replays the seed sequence.
//  7. SYNTH_OSC_PWM_EN, Pulse_width=16'h4000, 24'h100000, square: 4 of every 16 samples = 16'h7FFF.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice oscillator: waveform encodings,
// sample limits, noise LFSR taps, handshake states and a triangle helper.
package synth_pkg;

    localparam int SAMPLE_W = 16;

    localparam logic [SAMPLE_W-1:0] S_MAX = 16'h7FFF;
    localparam logic [SAMPLE_W-1:0] S_MIN = 16'h8000;

    // Noise LFSR taps 16,14,13,11 expressed as zero-based bit indices.
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    typedef enum logic [1:0] {
        WAVE_SAW = 2'b00,
        WAVE_SQR = 2'b01,
        WAVE_TRI = 2'b10,
        WAVE_NOI = 2'b11
    } wave_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } hs_state_t;

    // Fold the upper half of the phase back down, then recentre to signed.
    function automatic logic [SAMPLE_W-1:0] tri_fold(input logic [SAMPLE_W-1:0] p);
        logic [SAMPLE_W-2:0] t;
        t = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
        return {t, 1'b0} ^ S_MIN;
    endfunction

endpackage

// File: rtl/synth_lfsr.sv
// 16-bit Fibonacci LFSR for the noise waveform. Shifts left, feedback
// enters bit 0, advances only when Step_en is high.
module synth_lfsr
    import synth_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Sys_clk,
    input  logic        Syn_rst,
    input  logic        Step_en,
    output logic [15:0] Lfsr_state
);

    logic feedback;

    assign feedback = Lfsr_state[LFSR_TAP_A] ^ Lfsr_state[LFSR_TAP_B]
                    ^ Lfsr_state[LFSR_TAP_C] ^ Lfsr_state[LFSR_TAP_D];

    // Reseed on reset, otherwise shift once per enabled step.
    always_ff @(posedge Sys_clk) begin
        if (Syn_rst) begin
            Lfsr_state <= SEED;
        end else if (Step_en) begin
            Lfsr_state <= {Lfsr_state[14:0], feedback};
        end
    end

endmodule

// File: rtl/synth_phase_osc.sv
// Per-voice phase-accumulator oscillator. Advances once per rising edge of
// the Syn_clk update clock and emits one signed sample (saw, square,
// triangle or noise) one Sys_clk later. Frequency words arrive over a
// valid/ready handshake and are applied only at phase wrap.
//
// Build option: SYNTH_OSC_PWM_EN - when defined the square duty threshold
// comes from Pulse_width; otherwise it is fixed at 50 % and Pulse_width is
// ignored.
//
// Handshake states:
//   state   | meaning
//   ST_IDLE | no word pending, Freq_ready high (while Syn_ce)
//   ST_PEND | word held in pending, waiting for a wrap tick (or
//           | copied at once when active_freq is zero)
module synth_phase_osc
    import synth_pkg::*;
#(
    parameter int          ACC_W     = 24,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             Sys_clk,
    input  logic             Syn_rst,
    input  logic             Syn_ce,
    input  logic             Syn_clk,
    input  logic [ACC_W-1:0] Freq_word,
    input  logic             Freq_valid,
    output logic             Freq_ready,
    input  logic [1:0]       Wave_sel,
    input  logic [15:0]      Pulse_width,
    output logic [15:0]      Sample,
    output logic             Sample_val,
    output logic             Phase_wrap
);

    logic               syn_q;
    logic               tick;
    logic [ACC_W-1:0]   phase;
    logic [ACC_W-1:0]   active_freq;
    logic [ACC_W-1:0]   pending;
    logic [ACC_W:0]     phase_sum;
    logic               carry;
    logic               tick_q;
    logic               wrap_q;
    logic               xfer;
    logic               copy;
    hs_state_t          state;
    hs_state_t          state_nxt;
    logic [15:0]        p;
    logic [15:0]        duty;
    logic [15:0]        wave_nxt;
    logic [15:0]        lfsr_state;

    assign tick      = Syn_ce & Syn_clk & ~syn_q;
    assign phase_sum = {1'b0, phase} + {1'b0, active_freq};
    assign carry     = phase_sum[ACC_W];
    assign xfer      = Freq_valid & Freq_ready;
    assign copy      = (state == ST_PEND) & Syn_ce
                     & ((active_freq == '0) | (tick & carry));
    assign p         = phase[ACC_W-1 -: 16];

`ifdef SYNTH_OSC_PWM_EN
    assign duty = Pulse_width;
`else
    logic unused_pulse_width;
    assign unused_pulse_width = ^Pulse_width;
    assign duty = S_MIN;
`endif

    // Edge detector on the divider's update clock; frozen while disabled.
    always_ff @(posedge Sys_clk) begin
        if (Syn_rst) begin
            syn_q <= 1'b0;
        end else if (Syn_ce) begin
            syn_q <= Syn_clk;
        end
    end

    // Phase accumulator plus the tick/carry flags the sample stage consumes.
    always_ff @(posedge Sys_clk) begin
        if (Syn_rst) begin
            phase  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else if (Syn_ce) begin
            tick_q <= tick;
            wrap_q <= tick & carry;
            if (tick) begin
                phase <= phase_sum[ACC_W-1:0];
            end
        end
    end

    // Pending and active frequency words; a word lands in active only on copy.
    always_ff @(posedge Sys_clk) begin
        if (Syn_rst) begin
            pending     <= '0;
            active_freq <= '0;
        end else begin
            if (xfer) begin
                pending <= Freq_word;
            end
            if (copy) begin
                active_freq <= pending;
            end
        end
    end

    // Handshake state register.
    always_ff @(posedge Sys_clk) begin
        if (Syn_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake next-state and ready output.
    always_comb begin
        state_nxt  = state;
        Freq_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                Freq_ready = Syn_ce;
                if (xfer) begin
                    state_nxt = ST_PEND;
                end
            end
            ST_PEND: begin
                if (copy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Waveform generation from the top 16 phase bits or the LFSR.
    always_comb begin
        wave_nxt = p ^ S_MIN;
        case (wave_t'(Wave_sel))
            WAVE_SAW: wave_nxt = p ^ S_MIN;
            WAVE_SQR: wave_nxt = (p < duty) ? S_MAX : S_MIN;
            WAVE_TRI: wave_nxt = tri_fold(p);
            WAVE_NOI: wave_nxt = lfsr_state;
            default:  wave_nxt = p ^ S_MIN;
        endcase
    end

    // Sample register, one Sys_clk behind the tick that moved the phase.
    always_ff @(posedge Sys_clk) begin
        if (Syn_rst) begin
            Sample     <= '0;
            Sample_val <= 1'b0;
            Phase_wrap <= 1'b0;
        end else begin
            Sample_val <= Syn_ce & tick_q;
            Phase_wrap <= Syn_ce & tick_q & wrap_q;
            if (Syn_ce & tick_q) begin
                Sample <= wave_nxt;
            end
        end
    end

    synth_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Sys_clk    (Sys_clk),
        .Syn_rst    (Syn_rst),
        .Step_en    (tick),
        .Lfsr_state (lfsr_state)
    );

endmodule
